rc4_keystream: RTL and testbench
================================

# rc4_keystream

RC4 keystream generator feeding the byte-wise XOR encrypt/decrypt stage. After reset it latches the password, runs the 256-entry state fill and the key-scheduling pass, then raises `init_done`. From then on it delivers one keystream byte `K` per accepted valid/ready transfer. The downstream stage XORs each byte with plaintext or ciphertext; encrypt and decrypt share this block unchanged.

## Interface
- `KEY_BYTES`, default 1: password length in bytes, range 1..32. Byte m is `password_input[8m+7:8m]`, and byte 0 is the first key byte.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `password_input`  in  8*KEY_BYTES  RC4 key; captured once per reset (see Operation).
- `output_ready`  in  1  consumer accepts `K` on this edge when `valid`=1.
- `K`  out  8  current keystream byte.
- `valid`  out  1  `K` holds an unconsumed keystream byte.
- `init_done`  out  1  key scheduling complete; stays high until the next reset.

## Operation
- State array S: 256×8 flops, so reads and a swap complete in the same cycle. Indices `i` and `j` are 8-bit and wrap mod 256. Key index `kidx` runs 0..KEY_BYTES-1 and wraps to 0.
- FSM states: FILL → KSA → GEN. There are no other states. No path leads back out of GEN except reset.
- **FILL**
  - First edge after reset release: latch `password_input` into the key register. Later changes to the input are ignored until the next reset.
  - Every edge: S[i] ← i, i++.
  - When i=255 is written: i←0, j←0, kidx←0, go to KSA.
- **KSA** (one iteration per edge)
  - j' = j + S[i] + key[kidx], mod 256.
  - Swap S[i] and S[j'].
  - j←j', i++, kidx++ with wrap.
  - After the i=255 iteration: i←0, j←0, init_done←1, go to GEN.
- **GEN**
  - A byte is generated on an edge when `!valid || output_ready`.
  - Compute i' = i+1, then j' = j + S[i'].
  - Swap S[i'] and S[j'].
  - t = S[i'] + S[j'] (pre-swap values, mod 256).
  - K ← post-swap S[t]. Forward explicitly: t==i' gives old S[j']; t==j' gives old S[i']; i'==j' gives old S[i'].
  - i←i', j←j', valid←1.
  - If `valid && !output_ready`: hold K, valid, S, i and j unchanged.
- `output_ready` is ignored outside GEN.
- Reset values: K=0, valid=0, init_done=0, i=j=kidx=0, state=FILL. S contents are don't-care at reset; FILL overwrites all of them.
- Reset asserted at any point, including mid-KSA or mid-stream, aborts immediately. The key is re-latched and the full init reruns.

## Timing
- Edges are counted from the first rising edge after `rst` deasserts, called edge 0.
- FILL: edges 0–255. KSA: edges 256–511.
- `init_done` is high after edge 511.
- First `valid`=1 with the first keystream byte appears after edge 512.
- With `output_ready` held at 1, a new byte arrives every edge. Throughput is 1 byte/cycle and latency from acceptance to the next byte is 1 cycle.
- Backpressure rule: while `valid`=1 and `output_ready`=0, K is held stable and no keystream is skipped or duplicated.
- `valid` never drops while in GEN once it has risen.
- Keystream generation uses no cycles until a byte is consumed.
- `init_done` rises exactly one edge before the first `valid`.

## Test plan
- KEY_BYTES=3, password_input=24'h79654B ("Key"), output_ready=1 → init_done rises after edge 511, valid after edge 512. K sequence: EB 9F 77 81 B7 34 CA 72 A7 19.
- KEY_BYTES=4, password_input=32'h696B6957 ("Wiki") → K sequence: 60 44 DB 6D 41 B7.
- "Key" vector with output_ready randomly toggled → the accepted bytes are still EB 9F 77 81 B7 34 CA 72 A7 19. K is stable on every stalled cycle and valid never drops.
- output_ready=1 throughout init, plus password_input changed at edge 5 → valid stays 0 until edge 512. The keystream matches the key latched at edge 0.
- Reset asserted at edge 300 (mid-KSA), and again after 4 bytes of GEN → outputs go to 0 asynchronously. After release, init takes the full 512 edges and the stream restarts at EB.
- KEY_BYTES=1, password_input=8'h00 → compare 1024 bytes against a software RC4 model, exercising the i/j wrap and the t==i'/t==j' forwarding cases.

Source files
------------

// File: rtl/rc4_keystream.sv
// RC4 keystream generator.
// After reset it fills the 256-entry state array, runs the key schedule using
// the password latched on the first edge, and then hands out one keystream
// byte per accepted valid/ready transfer. Because the same keystream drives
// both encryption and decryption, this block has no mode input.
module rc4_keystream #(
  parameter int KEY_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*KEY_BYTES-1:0] password_input,
  input  logic                   output_ready,
  output logic [7:0]             K,
  output logic                   valid,
  output logic                   init_done
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    KSA  = 2'd1,
    GEN  = 2'd2
  } state_t;

  state_t state, state_next;

  // State array kept in flops so that reads and a swap finish in one cycle
  logic [7:0] s_mem [256];

  logic [7:0]             i_idx;
  logic [7:0]             j_idx;
  logic [KW-1:0]          kidx;
  logic [8*KEY_BYTES-1:0] key_reg;

  logic fill_en, ksa_en, gen_en;
  logic latch_key, gen_fire;

  logic [7:0] key_byte;
  logic [7:0] ksa_j;
  logic [7:0] gen_i, gen_si, gen_j, gen_sj, gen_t, gen_k;
  logic [7:0] swap_a, swap_b;

  // Phase register: FILL, then KSA, then GEN until the next reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Each init phase ends after its i=255 step; GEN is terminal
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (i_idx == 8'hFF) state_next = KSA;
      KSA:     if (i_idx == 8'hFF) state_next = GEN;
      GEN:     state_next = GEN;
      default: state_next = FILL;
    endcase
  end

  // Decode the current phase into the datapath enables
  always_comb begin
    fill_en = 1'b0;
    ksa_en  = 1'b0;
    gen_en  = 1'b0;
    case (state)
      FILL:    fill_en = 1'b1;
      KSA:     ksa_en  = 1'b1;
      GEN:     gen_en  = 1'b1;
      default: ;
    endcase
  end

  // The password is sampled only on the very first FILL step
  assign latch_key = fill_en && (i_idx == 8'h00);

  // A new byte is produced when the output slot is empty or being consumed
  assign gen_fire = gen_en && (!valid || output_ready);

  // Select key byte kidx from the latched password
  always_comb begin
    key_byte = 8'h00;
    for (int m = 0; m < KEY_BYTES; m++) begin
      if (kidx == KW'(m)) key_byte = key_reg[8*m +: 8];
    end
  end

  assign ksa_j  = j_idx + s_mem[i_idx] + key_byte;
  assign gen_i  = i_idx + 8'd1;
  assign gen_si = s_mem[gen_i];
  assign gen_j  = j_idx + gen_si;
  assign gen_sj = s_mem[gen_j];
  assign gen_t  = gen_si + gen_sj;

  // Output byte is post-swap S[t]; forward the swapped values instead of
  // reading the array, which still holds the pre-swap contents this cycle
  always_comb begin
    gen_k = s_mem[gen_t];
    if (gen_t == gen_i) begin
      gen_k = gen_sj;
    end else if (gen_t == gen_j) begin
      gen_k = gen_si;
    end
  end

  // KSA and GEN share one swap port; only the addresses differ
  always_comb begin
    swap_a = gen_i;
    swap_b = gen_j;
    if (ksa_en) begin
      swap_a = i_idx;
      swap_b = ksa_j;
    end
  end

  // State array: identity fill, then swaps; contents need no reset
  always_ff @(posedge clk) begin
    if (fill_en) begin
      s_mem[i_idx] <= i_idx;
    end else if (ksa_en || gen_fire) begin
      s_mem[swap_a] <= s_mem[swap_b];
      s_mem[swap_b] <= s_mem[swap_a];
    end
  end

  // Indices, latched key and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_idx     <= 8'h00;
      j_idx     <= 8'h00;
      kidx      <= '0;
      key_reg   <= '0;
      K         <= 8'h00;
      valid     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      if (latch_key) key_reg <= password_input;
      if (fill_en) begin
        i_idx <= i_idx + 8'd1;
        if (i_idx == 8'hFF) begin
          j_idx <= 8'h00;
          kidx  <= '0;
        end
      end else if (ksa_en) begin
        i_idx <= i_idx + 8'd1;
        if (i_idx == 8'hFF) begin
          j_idx     <= 8'h00;
          kidx      <= '0;
          init_done <= 1'b1;
        end else begin
          j_idx <= ksa_j;
          kidx  <= (kidx == KW'(KEY_BYTES - 1)) ? '0 : kidx + KW'(1);
        end
      end else if (gen_fire) begin
        i_idx <= gen_i;
        j_idx <= gen_j;
        K     <= gen_k;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rc4_keystream.sv
// Testbench for rc4_keystream.
// Three instances (1, 3 and 4 key bytes) share clock, reset, ready and a
// 32-bit key bus; one of them is observed at a time. Expected keystreams come
// from published vectors or from a plain software RC4 model.
module tb_rc4_keystream;

  logic        clk = 1'b0;
  logic        rst;
  logic        output_ready;
  logic [31:0] key_in;

  logic [7:0] k1, k3, k4;
  logic       v1, v3, v4;
  logic       d1, d3, d4;

  int         sel;
  logic [7:0] obs_k;
  logic       obs_v;
  logic       obs_d;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  rc4_keystream #(.KEY_BYTES(1)) dut1 (
    .clk(clk), .rst(rst), .password_input(key_in[7:0]), .output_ready(output_ready),
    .K(k1), .valid(v1), .init_done(d1)
  );

  rc4_keystream #(.KEY_BYTES(3)) dut3 (
    .clk(clk), .rst(rst), .password_input(key_in[23:0]), .output_ready(output_ready),
    .K(k3), .valid(v3), .init_done(d3)
  );

  rc4_keystream #(.KEY_BYTES(4)) dut4 (
    .clk(clk), .rst(rst), .password_input(key_in[31:0]), .output_ready(output_ready),
    .K(k4), .valid(v4), .init_done(d4)
  );

  // Route the selected instance to the observation signals
  always_comb begin
    obs_k = k3;
    obs_v = v3;
    obs_d = d3;
    case (sel)
      1: begin obs_k = k1; obs_v = v1; obs_d = d1; end
      4: begin obs_k = k4; obs_v = v4; obs_d = d4; end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Textbook RC4: key schedule followed by n output bytes into exp_q
  function automatic void rc4Model(input logic [31:0] key, input int len, input int n);
    int s[256];
    int i, j, tmp, kb;
    exp_q.delete();
    for (int a = 0; a < 256; a++) s[a] = a;
    j = 0;
    for (int a = 0; a < 256; a++) begin
      kb = int'((key >> (8 * (a % len))) & 32'hFF);
      j = (j + s[a] + kb) % 256;
      tmp = s[a]; s[a] = s[j]; s[j] = tmp;
    end
    i = 0;
    j = 0;
    for (int b = 0; b < n; b++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      exp_q.push_back(8'(s[(s[i] + s[j]) % 256]));
    end
  endfunction

  // Hold reset with a new key on the bus
  task automatic holdReset(input logic [31:0] key);
    @(negedge clk);
    rst          = 1'b0;
    key_in       = key;
    output_ready = 1'b0;
    @(negedge clk);
  endtask

  // Assert reset between edges and confirm the outputs clear at once
  task automatic pulseAbort(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput({tag, "_abort_K"}, 32'(obs_k), 32'h0);
    checkOutput({tag, "_abort_valid"}, 32'(obs_v), 32'h0);
    checkOutput({tag, "_abort_init_done"}, 32'(obs_d), 32'h0);
    @(negedge clk);
  endtask

  // Release reset, check init timing, then collect nbytes accepted bytes
  task automatic applyStimulus(input string tag, input int nbytes, input bit rand_ready,
                               input bit glitch_key);
    int c;
    int accepted;
    int cycles;
    bit early_valid;
    bit prev_stall;
    logic [7:0] held_k;

    checkOutput({tag, "_reset_K"}, 32'(obs_k), 32'h0);
    checkOutput({tag, "_reset_valid"}, 32'(obs_v), 32'h0);
    checkOutput({tag, "_reset_init_done"}, 32'(obs_d), 32'h0);

    output_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(negedge clk);
    rst = 1'b1;
    c = 0;
    early_valid = 1'b0;
    while (c < 512) begin
      @(negedge clk);
      c++;
      if (obs_v) early_valid = 1'b1;
      if (glitch_key && c == 5) key_in = ~key_in;
      if (c == 511) checkOutput({tag, "_init_done_early"}, 32'(obs_d), 32'h0);
      if (rand_ready) output_ready = ($urandom_range(0, 3) != 0);
    end
    checkOutput({tag, "_init_done_at_511"}, 32'(obs_d), 32'h1);
    checkOutput({tag, "_valid_during_init"}, 32'(early_valid | obs_v), 32'h0);

    accepted   = 0;
    cycles     = 0;
    prev_stall = 1'b0;
    held_k     = 8'h00;
    while (accepted < nbytes && cycles < 4 * nbytes + 50) begin
      @(negedge clk);
      c++;
      cycles++;
      checkOutput({tag, "_valid_high"}, 32'(obs_v), 32'h1);
      if (prev_stall) begin
        checkOutput({tag, "_stall_K"}, 32'(obs_k), 32'(held_k));
      end
      output_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (obs_v && output_ready) begin
        checkOutput($sformatf("%s_byte%0d", tag, accepted), 32'(obs_k), 32'(exp_q[accepted]));
        accepted++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = obs_v;
        held_k     = obs_k;
      end
    end
    checkOutput({tag, "_byte_count"}, 32'(accepted), 32'(nbytes));
  endtask

  initial begin
    logic [31:0] rkey;
    rst          = 1'b0;
    output_ready = 1'b0;
    key_in       = 32'h0;
    sel          = 3;

    // Published "Key" vector, ready held high
    holdReset(32'h0079654B);
    exp_q = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    applyStimulus("key", 10, 1'b0, 1'b0);

    // Published "Wiki" vector on the 4-byte instance
    sel = 4;
    holdReset(32'h696B6957);
    exp_q = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
    applyStimulus("wiki", 6, 1'b0, 1'b0);

    // "Key" with random backpressure
    sel = 3;
    holdReset(32'h0079654B);
    exp_q = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    applyStimulus("key_bp", 10, 1'b1, 1'b0);

    // Password changes after the latch edge must be ignored
    holdReset(32'h0079654B);
    applyStimulus("key_glitch", 10, 1'b0, 1'b1);

    // Abort mid-KSA, then again after four GEN bytes, then a full run
    holdReset(32'h0079654B);
    @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    pulseAbort("ksa");
    applyStimulus("key_pre_abort", 4, 1'b0, 1'b0);
    pulseAbort("gen");
    applyStimulus("key_post_abort", 10, 1'b0, 1'b0);

    // Single zero key byte, long run through index wrap and forwarding cases
    sel = 1;
    holdReset(32'h0);
    rc4Model(32'h0, 1, 1024);
    applyStimulus("zero_long", 1024, 1'b0, 1'b0);

    // Random keys and random backpressure on every key width
    for (int r = 0; r < 2; r++) begin
      rkey = $urandom;
      sel = 3;
      holdReset(rkey);
      rc4Model(rkey, 3, 40);
      applyStimulus($sformatf("rand3_%0d", r), 40, 1'b1, 1'b0);
      rkey = $urandom;
      sel = 4;
      holdReset(rkey);
      rc4Model(rkey, 4, 40);
      applyStimulus($sformatf("rand4_%0d", r), 40, 1'b1, 1'b0);
      rkey = $urandom;
      sel = 1;
      holdReset(rkey);
      rc4Model(rkey, 1, 300);
      applyStimulus($sformatf("rand1_%0d", r), 300, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
